// File: rtl/sw_core_arbiter_if.sv
// Purpose : bundle of requester, response and SW-core handshake signals
//           for sw_core_arbiter.
// Ports   : slave modport = arbiter view, master modport = environment view.
// Latency : none (wiring only); backpressure is carried by the ready/valid pairs.
interface sw_core_arbiter_if #(
  parameter int SEQ_W = 256,
  parameter int RES_W = 64
);
  // requester side
  logic             req0_valid;
  logic             req1_valid;
  logic             req0_ready;
  logic             req1_ready;
  logic [SEQ_W-1:0] req0_ref;
  logic [SEQ_W-1:0] req1_ref;
  logic [SEQ_W-1:0] req0_read;
  logic [SEQ_W-1:0] req1_read;
  // result consumer side
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic             rsp_timeout;
  logic [RES_W-1:0] rsp_score;
  logic [RES_W-1:0] rsp_row;
  logic [RES_W-1:0] rsp_col;
  // SW core side
  logic             core_i_valid;
  logic             core_o_ready;
  logic [SEQ_W-1:0] core_ref;
  logic [SEQ_W-1:0] core_read;
  logic             core_i_ready;
  logic             core_o_valid;
  logic [RES_W-1:0] core_score;
  logic [RES_W-1:0] core_row;
  logic [RES_W-1:0] core_col;

  modport slave (
    input  req0_valid, req1_valid, req0_ref, req1_ref, req0_read, req1_read,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_timeout, rsp_score, rsp_row, rsp_col,
    input  rsp_ready,
    output core_i_valid, core_ref, core_read, core_i_ready,
    input  core_o_ready, core_o_valid, core_score, core_row, core_col
  );

  modport master (
    output req0_valid, req1_valid, req0_ref, req1_ref, req0_read, req1_read,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_timeout, rsp_score, rsp_row, rsp_col,
    output rsp_ready,
    input  core_i_valid, core_ref, core_read, core_i_ready,
    output core_o_ready, core_o_valid, core_score, core_row, core_col
  );
endinterface

// File: rtl/sw_core_arbiter.sv
// Purpose : round-robin arbiter sharing one Smith-Waterman core between two
//           requesters, with a per-job watchdog that turns a hung core into a
//           timeout response.
// Latency : grant -> core_i_valid 1 cycle; core result -> rsp_valid 1 cycle.
// Backpr. : core_i_valid held until core_o_ready; rsp held until rsp_ready;
//           requesters only see ready in IDLE.
// Ports   : avm_clk, avm_rst (async, active-high), bus (sw_core_arbiter_if.slave).
module sw_core_arbiter #(
  parameter int SEQ_W     = 256,
  parameter int RES_W     = 64,
  parameter int TO_CYCLES = 4096
) (
  input  logic                avm_clk,
  input  logic                avm_rst,
  sw_core_arbiter_if.slave    bus
);

  localparam int CNT_W = $clog2(TO_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TO_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic             r_last_grant;   // 1: requester 1 won the previous grant
  logic             r_id;
  logic             r_timeout;
  logic [SEQ_W-1:0] r_ref;
  logic [SEQ_W-1:0] r_read;
  logic [RES_W-1:0] r_score;
  logic [RES_W-1:0] r_row;
  logic [RES_W-1:0] r_col;

  logic             w_any_req;
  logic             w_gnt1;
  logic             w_cnt_lim;
  logic             w_req0_rdy;
  logic             w_req1_rdy;
  logic             w_core_i_valid;
  logic             w_core_i_ready;
  logic             w_rsp_valid;

  assign w_any_req = bus.req0_valid | bus.req1_valid;
  // Requester 1 wins when it is alone, or on a tie when requester 0 went last.
  assign w_gnt1    = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
  assign w_cnt_lim = (r_cnt == CNT_LIM);

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_req0_rdy     = 1'b0;
    w_req1_rdy     = 1'b0;
    w_core_i_valid = 1'b0;
    w_core_i_ready = 1'b0;
    w_rsp_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_req0_rdy  = ~w_gnt1;
          w_req1_rdy  = w_gnt1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_core_i_valid = 1'b1;
        if (bus.core_o_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_core_i_ready = 1'b1;
        if (bus.core_o_valid || w_cnt_lim) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_timeout    <= 1'b0;
      r_ref        <= '0;
      r_read       <= '0;
      r_score      <= '0;
      r_row        <= '0;
      r_col        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_any_req) begin
            r_ref        <= w_gnt1 ? bus.req1_ref  : bus.req0_ref;
            r_read       <= w_gnt1 ? bus.req1_read : bus.req0_read;
            r_id         <= w_gnt1;
            r_last_grant <= w_gnt1;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          // A result arriving on the limit cycle still counts as a normal result.
          if (bus.core_o_valid) begin
            r_score   <= bus.core_score;
            r_row     <= bus.core_row;
            r_col     <= bus.core_col;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
          end else if (w_cnt_lim) begin
            r_score   <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_timeout <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // The grant ready is combinational on the request, so mask it while reset
  // is held to keep every output quiet during reset.
  assign bus.req0_ready   = w_req0_rdy & ~avm_rst;
  assign bus.req1_ready   = w_req1_rdy & ~avm_rst;
  assign bus.core_i_valid = w_core_i_valid;
  assign bus.core_i_ready = w_core_i_ready;
  assign bus.core_ref     = r_ref;
  assign bus.core_read    = r_read;
  assign bus.rsp_valid    = w_rsp_valid;
  assign bus.rsp_id       = r_id;
  assign bus.rsp_timeout  = r_timeout;
  assign bus.rsp_score    = r_score;
  assign bus.rsp_row      = r_row;
  assign bus.rsp_col      = r_col;

endmodule

// File: tb/tb_sw_core_arbiter.sv
// Purpose : directed self-checking bench for sw_core_arbiter (TO_CYCLES=16).
// Latency : inputs driven and outputs sampled on the falling clock edge.
// Backpr. : bench plays requesters, core and consumer, stalling each in turn.
module tb_sw_core_arbiter;

  localparam int SEQ_W = 256;
  localparam int RES_W = 64;
  localparam logic [SEQ_W-1:0] REF_A  = {8{32'hA5A5_0001}};
  localparam logic [SEQ_W-1:0] READ_A = {8{32'h1234_5678}};
  localparam logic [SEQ_W-1:0] REF_B  = {8{32'hB0B0_0002}};
  localparam logic [SEQ_W-1:0] READ_B = {8{32'h8765_4321}};
  localparam logic [SEQ_W-1:0] REF_C  = {8{32'hC3C3_0003}};

  logic avm_clk;
  logic avm_rst;
  int   n_tests;
  int   n_fail;

  sw_core_arbiter_if #(.SEQ_W(SEQ_W), .RES_W(RES_W)) bus ();

  sw_core_arbiter #(.SEQ_W(SEQ_W), .RES_W(RES_W), .TO_CYCLES(16)) dut (
    .avm_clk (avm_clk),
    .avm_rst (avm_rst),
    .bus     (bus.slave)
  );

  initial avm_clk = 1'b0;
  always #5 avm_clk = ~avm_clk;

  task automatic tick();
    @(negedge avm_clk);
  endtask

  task automatic chk(input string tag, input logic [SEQ_W-1:0] obs, input logic [SEQ_W-1:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    int  bad;
    logic g;
    n_tests = 0;
    n_fail  = 0;
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_ref = '0; bus.req1_ref = '0; bus.req0_read = '0; bus.req1_read = '0;
    bus.rsp_ready = 0; bus.core_o_ready = 0; bus.core_o_valid = 0;
    bus.core_score = '0; bus.core_row = '0; bus.core_col = '0;
    avm_rst = 1'b1;

    // ---- reset state (request held valid to prove ready is masked)
    bus.req0_valid = 1;
    repeat (2) tick();
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_core_i_valid", bus.core_i_valid, 0);
    chk("rst_core_i_ready", bus.core_i_ready, 0);
    chk("rst_core_ref", bus.core_ref, 0);
    chk("rst_rsp_score", bus.rsp_score, 0);
    bus.req0_valid = 0;
    avm_rst = 1'b0;
    tick();

    // ---- single job
    bus.req0_valid = 1; bus.req0_ref = REF_A; bus.req0_read = READ_A;
    bus.req1_ref = REF_B; bus.req1_read = READ_B; bus.core_o_ready = 1;
    #1;
    chk("single_req0_ready", bus.req0_ready, 1);
    chk("single_req1_ready", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 0;
    chk("single_issue_valid", bus.core_i_valid, 1);
    chk("single_core_ref", bus.core_ref, REF_A);
    chk("single_core_read", bus.core_read, READ_A);
    chk("single_ready_pulse", bus.req0_ready, 0);
    tick();
    chk("single_wait_ivalid", bus.core_i_valid, 0);
    chk("single_wait_iready", bus.core_i_ready, 1);
    repeat (3) tick();
    bus.core_o_valid = 1; bus.core_score = 37; bus.core_row = 127; bus.core_col = 127;
    tick();
    bus.core_o_valid = 0;
    chk("single_rsp_valid", bus.rsp_valid, 1);
    chk("single_rsp_id", bus.rsp_id, 0);
    chk("single_rsp_score", bus.rsp_score, 37);
    chk("single_rsp_row", bus.rsp_row, 127);
    chk("single_rsp_col", bus.rsp_col, 127);
    chk("single_rsp_timeout", bus.rsp_timeout, 0);
    chk("single_resp_iready", bus.core_i_ready, 0);
    bus.rsp_ready = 1;
    tick();
    bus.rsp_ready = 0;
    chk("single_rsp_drop", bus.rsp_valid, 0);

    // ---- contention from a fresh reset: grants 0,1,0,1
    avm_rst = 1'b1;
    tick();
    avm_rst = 1'b0;
    tick();
    bus.req0_valid = 1; bus.req1_valid = 1;
    for (int k = 0; k < 4; k++) begin
      g = k[0];
      #1;
      chk($sformatf("cont%0d_req0_ready", k), bus.req0_ready, !g);
      chk($sformatf("cont%0d_req1_ready", k), bus.req1_ready, g);
      tick();
      chk($sformatf("cont%0d_core_ref", k), bus.core_ref, g ? REF_B : REF_A);
      chk($sformatf("cont%0d_no_ready", k), bus.req0_ready | bus.req1_ready, 0);
      tick();
      bus.core_o_valid = 1; bus.core_score = 64'(100 + k);
      tick();
      bus.core_o_valid = 0;
      chk($sformatf("cont%0d_rsp_valid", k), bus.rsp_valid, 1);
      chk($sformatf("cont%0d_rsp_id", k), bus.rsp_id, g);
      chk($sformatf("cont%0d_rsp_score", k), bus.rsp_score, 100 + k);
      bus.rsp_ready = 1;
      tick();
      bus.rsp_ready = 0;
    end
    bus.req0_valid = 0; bus.req1_valid = 0;

    // ---- backpressure on the core and on the consumer
    bus.core_o_ready = 0;
    bus.req1_valid = 1; bus.req1_ref = REF_C;
    #1;
    chk("bp_req1_ready", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 0; bus.req1_ref = REF_B;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.core_i_valid !== 1'b1 || bus.core_ref !== REF_C) bad++;
      tick();
    end
    chk("bp_issue_hold", 32'(bad), 0);
    bus.core_o_ready = 1;
    tick();
    chk("bp_issue_drop", bus.core_i_valid, 0);
    bus.core_o_valid = 1; bus.core_score = 55; bus.core_row = 3; bus.core_col = 4;
    tick();
    bus.core_o_valid = 0; bus.core_score = 1; bus.core_row = 1; bus.core_col = 1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.rsp_valid !== 1'b1 || bus.rsp_score !== 64'd55 ||
          bus.rsp_row !== 64'd3 || bus.rsp_col !== 64'd4 || bus.rsp_id !== 1'b1) bad++;
      tick();
    end
    chk("bp_rsp_hold", 32'(bad), 0);
    bus.rsp_ready = 1;
    tick();
    bus.rsp_ready = 0;
    chk("bp_rsp_drop", bus.rsp_valid, 0);

    // ---- watchdog timeout: 16 WAIT cycles then a zeroed timeout response
    bus.req0_valid = 1;
    tick();
    bus.req0_valid = 0;
    tick();
    bus.core_score = 99; bus.core_row = 98; bus.core_col = 97;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.rsp_valid !== 1'b0 || bus.core_i_ready !== 1'b1) bad++;
      tick();
    end
    chk("to_wait_len", 32'(bad), 0);
    chk("to_rsp_valid", bus.rsp_valid, 1);
    chk("to_rsp_timeout", bus.rsp_timeout, 1);
    chk("to_rsp_score", bus.rsp_score, 0);
    chk("to_rsp_row", bus.rsp_row, 0);
    chk("to_rsp_col", bus.rsp_col, 0);
    bus.rsp_ready = 1;
    tick();
    bus.rsp_ready = 0;
    // next job recovers normally
    bus.req1_valid = 1;
    tick();
    bus.req1_valid = 0;
    tick();
    bus.core_o_valid = 1; bus.core_score = 11;
    tick();
    bus.core_o_valid = 0;
    chk("post_to_rsp_valid", bus.rsp_valid, 1);
    chk("post_to_timeout", bus.rsp_timeout, 0);
    chk("post_to_score", bus.rsp_score, 11);
    chk("post_to_id", bus.rsp_id, 1);
    bus.rsp_ready = 1;
    tick();
    bus.rsp_ready = 0;

    // ---- result on the exact watchdog-limit cycle wins
    bus.req0_valid = 1;
    tick();
    bus.req0_valid = 0;
    tick();
    repeat (15) tick();
    chk("lim_still_wait", bus.rsp_valid, 0);
    bus.core_o_valid = 1; bus.core_score = 77;
    tick();
    bus.core_o_valid = 0;
    chk("lim_rsp_valid", bus.rsp_valid, 1);
    chk("lim_timeout", bus.rsp_timeout, 0);
    chk("lim_score", bus.rsp_score, 77);
    bus.rsp_ready = 1;
    tick();
    bus.rsp_ready = 0;

    // ---- reset in the middle of WAIT (this tie grants requester 1)
    bus.req0_valid = 1; bus.req1_valid = 1;
    tick();
    tick();
    tick();
    avm_rst = 1'b1;
    #1;
    chk("mid_rst_iready", bus.core_i_ready, 0);
    chk("mid_rst_ivalid", bus.core_i_valid, 0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_req0_ready", bus.req0_ready, 0);
    chk("mid_rst_req1_ready", bus.req1_ready, 0);
    chk("mid_rst_core_ref", bus.core_ref, 0);
    chk("mid_rst_rsp_id", bus.rsp_id, 0);
    chk("mid_rst_score", bus.rsp_score, 0);
    bus.req0_valid = 0; bus.req1_valid = 0; bus.core_o_valid = 1;
    tick();
    avm_rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid !== 1'b0 || bus.core_i_ready !== 1'b0) bad++;
      tick();
    end
    chk("mid_rst_no_rsp", 32'(bad), 0);
    bus.core_o_valid = 0;
    bus.req0_valid = 1; bus.req1_valid = 1;
    #1;
    chk("mid_rst_tie_req0", bus.req0_ready, 1);
    chk("mid_rst_tie_req1", bus.req1_ready, 0);
    bus.req0_valid = 0; bus.req1_valid = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
